cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_pc.sv | 16 +
 rtl/cpu_sequencer.sv | 74 +++++++
 tb/tb_cpu_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and instruction constants (CPU_SEQ_SINGLE_STEP_EN adds PAUSE)
package cpu_pkg;
  localparam int INSTR_W = 8;
  localparam int IMM_W = 4;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ = 3'b111;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
`ifdef CPU_SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;
endpackage

// File: rtl/cpu_pc.sv
// cpu_pc: program counter with load, increment and natural wrap
module cpu_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    if (!rst_n) pc <= '0;
    else if (load) pc <= load_val;
    else if (inc) pc <= pc + ADDR_W'(1);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute/writeback FSM with IR; CPU_SEQ_SINGLE_STEP_EN adds step port and PAUSE
module cpu_sequencer import cpu_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir_out,
  input  logic [2:0]         opcode,
  input  logic               sel_acc,
  input  logic               zero_flag,
  output logic               alu_en,
  output logic               acc_we,
  output logic               reg_we,
  output logic               busy,
  output logic               halted
);
  state_t state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc;
  logic is_alu, is_hlt, wb, pc_load, pc_inc;
  assign is_alu = !(opcode == OP_JMP || opcode == OP_JZ);
  assign is_hlt = opcode == OP_JZ && sel_acc;
  assign wb = state_q == S_WRITEBACK;
  assign pc_load = wb && (opcode == OP_JMP || (opcode == OP_JZ && !sel_acc && zero_flag));
  assign pc_inc = wb && !is_hlt && !pc_load;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ack) ir_q <= imem_data;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_d = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      S_WRITEBACK: state_d = is_hlt ? S_HALT : S_PAUSE;
      S_PAUSE:     state_d = step ? S_FETCH : S_PAUSE;
`else
      S_WRITEBACK: state_d = is_hlt ? S_HALT : run ? S_FETCH : S_IDLE;
`endif
      default:     state_d = state_q;
    endcase
  end
  cpu_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val ({{(ADDR_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]}),
    .pc       (pc)
  );
  assign imem_req = state_q == S_FETCH;
  assign imem_addr = pc;
  assign ir_out = ir_q;
  assign alu_en = state_q == S_EXECUTE && is_alu;
  assign acc_we = wb && is_alu && sel_acc;
  assign reg_we = wb && is_alu && !sel_acc;
  assign busy = !(state_q == S_IDLE || state_q == S_HALT);
  assign halted = state_q == S_HALT;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; expected fetch addresses are queued at each ack and popped at the next fetch
module tb_cpu_sequencer;
  logic clk = 0, rst_n = 0, run = 0, imem_ack = 0, zero_flag = 0, step = 0;
  logic [7:0] imem_data = 0, imem_addr, ir_out, model_pc = 0;
  logic [2:0] opcode;
  logic sel_acc, imem_req, alu_en, acc_we, reg_we, busy, halted;
  logic [7:0] sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // decoder model: sel_acc=ir[7], opcode=ir[6:4], immediate=ir[3:0]
  assign opcode = ir_out[6:4];
  assign sel_acc = ir_out[7];

  cpu_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir_out(ir_out), .opcode(opcode), .sel_acc(sel_acc), .zero_flag(zero_flag),
    .alu_en(alu_en), .acc_we(acc_we), .reg_we(reg_we), .busy(busy), .halted(halted)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_instr(input logic [7:0] ins, input int dly, input logic zf, input bit drop);
    logic [7:0] exp_addr, nxt;
    logic [2:0] op;
    logic alu, jmp, jz, hlt;
    int n;
    op = ins[6:4];
    alu = op < 3'd6;
    jmp = op == 3'b110;
    jz = op == 3'b111 && !ins[7];
    hlt = op == 3'b111 && ins[7];
    n = 0;
    while (!imem_req && n < 50) begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step = 1;
`endif
      @(negedge clk);
      n++;
    end
    step = 0;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_timeout ins=%h imem_req=%b want 1", ins, imem_req); end
    exp_addr = sb.size() > 0 ? sb.pop_front() : model_pc;
    checks++;
    if (imem_addr !== exp_addr) begin errors++; $display("FAIL fetch_addr ins=%h got %h want %h", ins, imem_addr, exp_addr); end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
        errors++; $display("FAIL fetch_hold cyc=%0d req=%b addr=%h want 1 %h", i, imem_req, imem_addr, exp_addr);
      end
    end
    imem_ack = 1; imem_data = ins; zero_flag = zf;
    @(negedge clk);
    imem_ack = 0;
    if (drop) run = 0;
    nxt = hlt ? model_pc : (jmp || (jz && zf)) ? {4'h0, ins[3:0]} : model_pc + 8'd1;
    if (!hlt) sb.push_back(nxt);
    model_pc = nxt;
    checks++;
    if ({ir_out, imem_req, busy, alu_en, acc_we, reg_we} !== {ins, 5'b01000}) begin
      errors++; $display("FAIL decode ins=%h got ir=%h req/busy/alu/acc/reg=%b%b%b%b%b want ir=%h 01000",
        ins, ir_out, imem_req, busy, alu_en, acc_we, reg_we, ins);
    end
    @(negedge clk);
    checks++;
    if ({busy, alu_en, acc_we, reg_we} !== {1'b1, alu, 2'b00}) begin
      errors++; $display("FAIL execute ins=%h got busy/alu/acc/reg=%b%b%b%b want 1%b00", ins, busy, alu_en, acc_we, reg_we, alu);
    end
    @(negedge clk);
    checks++;
    if ({busy, alu_en, acc_we, reg_we, imem_addr} !== {2'b10, alu && ins[7], alu && !ins[7], exp_addr}) begin
      errors++; $display("FAIL writeback ins=%h got busy/alu/acc/reg=%b%b%b%b pc=%h want 10%b%b pc=%h",
        ins, busy, alu_en, acc_we, reg_we, imem_addr, alu && ins[7], alu && !ins[7], exp_addr);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; run = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, busy, halted, alu_en, acc_we, reg_we, imem_addr, ir_out} !== 22'd0) begin
      errors++; $display("FAIL reset req/busy/halt/alu/acc/reg=%b%b%b%b%b%b addr=%h ir=%h want all 0",
        imem_req, busy, halted, alu_en, acc_we, reg_we, imem_addr, ir_out);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({imem_req, busy} !== 2'b00) begin errors++; $display("FAIL idle_no_run req/busy=%b%b want 00", imem_req, busy); end
  endtask

  task automatic test_alu_acc;
    sb.push_back(8'h00);
    run = 1;
    do_instr(8'h83, 1, 0, 0);
  endtask

  task automatic test_jmp_jz;
    do_instr(8'h65, 0, 0, 0);
    do_instr(8'h72, 0, 1, 0);
    do_instr(8'h72, 0, 0, 0);
    do_instr(8'h01, 4, 0, 0);
  endtask

  task automatic test_run_drop;
`ifndef CPU_SEQ_SINGLE_STEP_EN
    do_instr(8'h01, 0, 0, 1);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({imem_req, busy} !== 2'b00) begin errors++; $display("FAIL run_drop_idle req/busy=%b%b want 00", imem_req, busy); end
    end
`endif
    run = 1;
  endtask

  task automatic test_wrap;
    do_instr(8'h6F, 0, 0, 0);
    while (model_pc != 8'hFF) do_instr(8'h01, 0, 0, 0);
    do_instr(8'h83, 0, 0, 0);
  endtask

  task automatic test_halt;
    do_instr(8'hF0, 0, 0, 0);
    run = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({halted, busy, imem_req, imem_addr} !== {3'b100, model_pc}) begin
        errors++; $display("FAIL halt_hold cyc=%0d halt/busy/req=%b%b%b pc=%h want 100 %h", i, halted, busy, imem_req, imem_addr, model_pc);
      end
    end
    rst_n = 0; run = 0;
    @(negedge clk);
    checks++;
    if ({halted, busy, imem_req, imem_addr, ir_out} !== 19'd0) begin
      errors++; $display("FAIL halt_reset halt/busy/req=%b%b%b pc=%h ir=%h want 000 00 00", halted, busy, imem_req, imem_addr, ir_out);
    end
    rst_n = 1;
    sb.delete();
    model_pc = 0;
  endtask

  task automatic test_reset_mid_fetch;
    int n;
    run = 1;
    sb.push_back(8'h00);
    do_instr(8'h69, 0, 0, 0);
    n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, sb.pop_front()}) begin
      errors++; $display("FAIL midfetch_addr req=%b addr=%h want 1 09", imem_req, imem_addr);
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({imem_req, busy, imem_addr} !== 10'd0) begin
      errors++; $display("FAIL midfetch_reset req/busy=%b%b pc=%h want 00 00", imem_req, busy, imem_addr);
    end
    rst_n = 1; run = 0;
    sb.delete();
    model_pc = 0;
  endtask

  task automatic test_single_step;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    run = 1;
    sb.push_back(8'h00);
    do_instr(8'h01, 0, 0, 0);
    repeat (6) begin
      @(negedge clk);
      checks++;
      if ({busy, imem_req} !== 2'b10) begin errors++; $display("FAIL pause busy/req=%b%b want 10", busy, imem_req); end
    end
    step = 1;
    @(negedge clk);
    step = 0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, sb.pop_front()}) begin
      errors++; $display("FAIL step_fetch req=%b addr=%h want 1 01", imem_req, imem_addr);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_alu_acc;
    test_jmp_jz;
    test_run_drop;
    test_wrap;
    test_halt;
    test_reset_mid_fetch;
    test_single_step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
